// File: rtl/field_arith_pkg.sv
// Shared field-arithmetic definitions: operand width, driver FSM states and
// the counter-width helper used for the WAIT timeout.
package field_arith_pkg;

    localparam int unsigned F_NBITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } fsm_state_e;

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/field_op_fifo.sv
// Operand FIFO: power-of-two depth, wrap-bit pointers for full/empty,
// same-cycle push and pop allowed whenever the FIFO is not full.
module field_op_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/field_arith_drv.sv
// Driver for a field arithmetic unit: queues operand pairs, issues them one at
// a time with a single-cycle start strobe, and returns results in order.
module field_arith_drv
    import field_arith_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_BITS   = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [F_NBITS-1:0]  in_a,
    input  logic [F_NBITS-1:0]  in_b,
    input  logic [TAG_BITS-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [F_NBITS-1:0]  out_c,
    output logic [TAG_BITS-1:0] out_tag,
    output logic                arith_en,
    output logic [F_NBITS-1:0]  arith_a,
    output logic [F_NBITS-1:0]  arith_b,
    input  logic                arith_ready,
    input  logic                arith_ready_pulse,
    input  logic [F_NBITS-1:0]  arith_c,
    output logic                busy,
    output logic                timeout_err
);
    localparam int unsigned CW = cnt_width(TIMEOUT);
    localparam int unsigned DW = 2 * F_NBITS + TAG_BITS;

    fsm_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [F_NBITS-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic [TAG_BITS-1:0] tag_q, tag_d, otag_q, otag_d;
    logic                ov_q, ov_d, err_q, err_d;

    logic                fifo_full, fifo_empty, fifo_pop;
    logic [DW-1:0]       fifo_dout;

    // Full FIFO refuses pushes even when a pop happens in the same cycle.
    assign in_ready = ~fifo_full & ~rst;

    field_op_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid & in_ready),
        .din   ({in_tag, in_a, in_b}),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        c_d      = c_q;
        otag_d   = otag_q;
        ov_d     = ov_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        if (ov_q && out_ready) ov_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && (!ov_q || out_ready) && arith_ready) begin
                    fifo_pop            = 1'b1;
                    {tag_d, a_d, b_d}   = fifo_dout;
                    state_d             = ST_FIRE;
                end
            end
            ST_FIRE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A pulse on the final counted cycle still completes the op.
                if (arith_ready_pulse) begin
                    c_d     = arith_c;
                    otag_d  = tag_q;
                    ov_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            c_q     <= '0;
            otag_q  <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            c_q     <= c_d;
            otag_q  <= otag_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    assign arith_en    = (state_q == ST_FIRE);
    assign arith_a     = a_q;
    assign arith_b     = b_q;
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = ov_q;
    assign out_c       = c_q;
    assign out_tag     = otag_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_field_arith_drv.sv
// Directed bench for field_arith_drv with a behavioural adder unit model
// (start-to-pulse spacing NCYC cycles, optional mute / hold / forced pulse).
module tb_field_arith_drv;
    import field_arith_pkg::*;

    localparam int unsigned NCYC = 3;
    localparam int unsigned TMO  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0, out_c, arith_a, arith_b, arith_c;
    logic [3:0] in_tag = '0, out_tag;
    logic arith_en, arith_ready, arith_ready_pulse, busy, timeout_err;

    field_arith_drv #(
        .FIFO_DEPTH (4),
        .TAG_BITS   (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_a              (in_a),
        .in_b              (in_b),
        .in_tag            (in_tag),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_c             (out_c),
        .out_tag           (out_tag),
        .arith_en          (arith_en),
        .arith_a           (arith_a),
        .arith_b           (arith_b),
        .arith_ready       (arith_ready),
        .arith_ready_pulse (arith_ready_pulse),
        .arith_c           (arith_c),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    // Unit model: start seen in cycle F, pulse during cycle F+NCYC.
    logic        pend = 1'b0, mute = 1'b0, hold = 1'b0, force_pulse = 1'b0;
    int unsigned mcnt = 0;
    logic [7:0]  msum = '0;
    always @(posedge clk) begin
        if (arith_en && !mute) begin
            pend <= 1'b1;
            mcnt <= NCYC - 1;
            msum <= arith_a + arith_b;
        end else if (pend) begin
            if (mcnt == 0) pend <= 1'b0;
            else           mcnt <= mcnt - 1;
        end
    end
    assign arith_ready       = !pend && !hold;
    assign arith_ready_pulse = (pend && mcnt == 0) || force_pulse;
    assign arith_c           = msum;

    int unsigned cyc = 0;
    int unsigned en_q[$];
    typedef struct { logic [3:0] tag; logic [7:0] c; } res_t;
    res_t res_q[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (arith_en) en_q.push_back(cyc);
        if (out_valid && out_ready) res_q.push_back('{out_tag, out_c});
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        int n = 0;
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) chk("push_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_en(output bit ok);
        int n = 0;
        while (!arith_en && n < 40) begin tick(); n++; end
        ok = arith_en;
    endtask

    task automatic wait_ov(output bit ok);
        int n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        ok = out_valid;
    endtask

    typedef struct { logic [7:0] a; logic [7:0] b; logic [3:0] tag; logic [7:0] c; } vec_t;
    vec_t vecs[5];
    vec_t burst[4];

    initial begin
        bit ok;
        int k, e0;
        bit stable, seen_ov, seen_busy;

        vecs[0] = '{8'd3,   8'd5,   4'd1,  8'd8};
        vecs[1] = '{8'd255, 8'd1,   4'd15, 8'd0};
        vecs[2] = '{8'd200, 8'd100, 4'd2,  8'd44};
        vecs[3] = '{8'd0,   8'd0,   4'd0,  8'd0};
        vecs[4] = '{8'd127, 8'd128, 4'd9,  8'd255};
        burst[0] = '{8'd1,  8'd2, 4'd0, 8'd3};
        burst[1] = '{8'd11, 8'd3, 4'd1, 8'd14};
        burst[2] = '{8'd21, 8'd4, 4'd2, 8'd25};
        burst[3] = '{8'd31, 8'd5, 4'd3, 8'd36};

        // Reset state
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_arith_en", arith_en, 0);
        chk("rst_arith_ab", {arith_a, arith_b}, 0);
        chk("rst_out", {out_tag, out_c}, 0);
        chk("rst_err", timeout_err, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Single op: FIRE cycle plus NCYC+1 cycles to out_valid
        out_ready = 1'b1;
        push_op(8'd3, 8'd5, 4'd1);
        wait_en(ok);
        chk("single_en_seen", ok, 1);
        chk("single_arith_ab", {arith_a, arith_b}, {8'd3, 8'd5});
        tick();
        chk("single_en_one_cycle", arith_en, 0);
        chk("single_hold_ab", {arith_a, arith_b}, {8'd3, 8'd5});
        k = 1;
        while (!out_valid && k < 30) begin tick(); k++; end
        chk("single_latency", k, NCYC + 1);
        chk("single_out", {out_tag, out_c}, {4'd1, 8'd8});
        tick();
        chk("single_drain", out_valid, 0);

        // Table of individual ops
        for (int i = 0; i < 5; i++) begin
            push_op(vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_ov(ok);
            chk($sformatf("vec%0d_ov", i), ok, 1);
            chk($sformatf("vec%0d_out", i), {out_tag, out_c}, {vecs[i].tag, vecs[i].c});
            tick();
        end

        // Burst: fill FIFO while unit busy-held, refused 5th push, ordered drain
        en_q.delete(); res_q.delete();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_op(burst[i].a, burst[i].b, burst[i].tag);
        in_a = 8'd99; in_b = 8'd99; in_tag = 4'd9; in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready) stable = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        chk("burst_full_refuse", stable, 1);
        hold = 1'b0;
        k = 0;
        while (res_q.size() < 4 && k < 100) begin tick(); k++; end
        for (int i = 0; i < 20; i++) tick();
        chk("burst_result_count", res_q.size(), 4);
        for (int i = 0; i < 4 && i < res_q.size(); i++)
            chk($sformatf("burst_res%0d", i), {res_q[i].tag, res_q[i].c}, {burst[i].tag, burst[i].c});
        chk("burst_en_count", en_q.size(), 4);
        for (int i = 1; i < 4 && i < en_q.size(); i++)
            chk($sformatf("burst_en_gap%0d", i), en_q[i] - en_q[i-1], NCYC + 2);

        // Backpressure: first result held, no second FIRE until drained
        en_q.delete(); res_q.delete();
        out_ready = 1'b0;
        hold = 1'b1;
        push_op(8'd40, 8'd2, 4'd6);
        push_op(8'd50, 8'd60, 4'd7);
        hold = 1'b0;
        wait_ov(ok);
        chk("bp_first_ov", ok, 1);
        chk("bp_first_out", {out_tag, out_c}, {4'd6, 8'd42});
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!out_valid || out_c != 8'd42 || out_tag != 4'd6) stable = 1'b0;
        end
        chk("bp_held_stable", stable, 1);
        chk("bp_no_second_fire", en_q.size(), 1);
        out_ready = 1'b1;
        k = 0;
        while (res_q.size() < 2 && k < 40) begin tick(); k++; end
        chk("bp_result_count", res_q.size(), 2);
        if (res_q.size() == 2)
            chk("bp_second_out", {res_q[1].tag, res_q[1].c}, {4'd7, 8'd110});
        tick();

        // Timeout: muted unit, abort after FIRE + TMO WAIT cycles
        mute = 1'b1;
        push_op(8'd7, 8'd7, 4'd3);
        wait_en(ok);
        chk("tmo_en_seen", ok, 1);
        k = 0;
        while (busy && k < 50) begin tick(); k++; end
        chk("tmo_busy_cycles", k, TMO + 1);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_out_valid", out_valid, 0);
        mute = 1'b0;
        push_op(8'd20, 8'd22, 4'd4);
        wait_ov(ok);
        chk("tmo_next_ov", ok, 1);
        chk("tmo_next_out", {out_tag, out_c}, {4'd4, 8'd42});
        chk("tmo_err_sticky", timeout_err, 1);
        tick();

        // Reset mid-WAIT with ops queued; late pulse must be ignored
        hold = 1'b1;
        push_op(8'd1, 8'd1, 4'd1);
        push_op(8'd2, 8'd2, 4'd2);
        push_op(8'd3, 8'd3, 4'd3);
        hold = 1'b0;
        wait_en(ok);
        chk("rmw_en_seen", ok, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rmw_in_ready_in_rst", in_ready, 0);
        rst = 1'b0;
        e0 = en_q.size();
        seen_ov = 1'b0; seen_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen_ov = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        chk("rmw_no_out_valid", seen_ov, 0);
        chk("rmw_no_busy", seen_busy, 0);
        chk("rmw_fifo_empty_no_fire", en_q.size(), e0);
        chk("rmw_err_cleared", timeout_err, 0);
        chk("rmw_out_cleared", {out_tag, out_c}, 0);

        // Spurious pulse while IDLE
        force_pulse = 1'b1;
        tick(); tick();
        force_pulse = 1'b0;
        tick();
        chk("spur_out_valid", out_valid, 0);
        chk("spur_busy", busy, 0);
        chk("spur_out", {out_tag, out_c}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
